axil_slave_regfile: RTL and testbench



---
 rtl/axil_slave_regfile.sv | 159 +++++++++++++++
 tb/tb_axil_slave_regfile.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers with byte-strobe writes.
// Define AXIL_SLV_RANGE_ERR_EN to answer out-of-range word indices with SLVERR instead of aliasing.
module axil_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] NREGS = 32'(NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  logic aw_held, aw_held_nxt, w_held, w_held_nxt;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] aw_idx, ar_idx, wr_idx, rd_idx;
  logic wr_ok, rd_ok;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data, rd_word;
  logic [STRB_W-1:0] w_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Address decode: either reject or alias indices beyond the implemented registers.
  always_comb begin
`ifdef AXIL_SLV_RANGE_ERR_EN
    wr_idx = aw_idx;
    wr_ok  = 32'(aw_idx) < NREGS;
    rd_idx = ar_idx;
    rd_ok  = 32'(ar_idx) < NREGS;
`else
    wr_idx = IDX_W'(32'(aw_idx) % NREGS);
    wr_ok  = 1'b1;
    rd_idx = IDX_W'(32'(ar_idx) % NREGS);
    rd_ok  = 1'b1;
`endif
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_word = regs[RIDX_W'(i)];
  end

  // Write FSM: commit only once both address and data sit in their holding registers.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs        = S_AXI_WVALID && S_AXI_WREADY;
    commit      = (wstate == W_COLLECT) && aw_held && w_held;
    wstate_nxt  = wstate;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    case (wstate)
      W_IDLE, W_COLLECT: begin
        if (commit) begin
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          wstate_nxt  = W_RESP;
        end else begin
          if (aw_hs) aw_held_nxt = 1'b1;
          if (w_hs)  w_held_nxt  = 1'b1;
          if (aw_held_nxt || w_held_nxt) wstate_nxt = W_COLLECT;
        end
      end
      W_RESP: if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
    rstate_nxt = rstate;
    if (rstate == R_IDLE) begin
      if (ar_hs) rstate_nxt = R_RESP;
    end else if (S_AXI_RREADY) begin
      rstate_nxt = R_IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate        <= W_IDLE;
      rstate        <= R_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      wstate        <= wstate_nxt;
      rstate        <= rstate_nxt;
      aw_held       <= aw_held_nxt;
      w_held        <= w_held_nxt;
      // Readies are registered from next-state so no input reaches an output combinationally.
      S_AXI_BVALID  <= (wstate_nxt == W_RESP);
      S_AXI_AWREADY <= !aw_held_nxt && (wstate_nxt != W_RESP);
      S_AXI_WREADY  <= !w_held_nxt && (wstate_nxt != W_RESP);
      if (commit) S_AXI_BRESP <= wr_ok ? 2'b00 : 2'b10;
      S_AXI_RVALID  <= (rstate_nxt == R_RESP);
      S_AXI_ARREADY <= (rstate_nxt == R_IDLE);
      if (ar_hs) begin
        S_AXI_RDATA <= rd_ok ? rd_word : '0;
        S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    if (w_hs) begin
      w_data <= S_AXI_WDATA;
      w_strb <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[RIDX_W'(i)] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_idx == IDX_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) regs[RIDX_W'(i)][8*b +: 8] <= w_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile: vector table, corner sequences, randomized traffic vs. a register model.
module tb_axil_slave_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_slave_regfile dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

`ifdef AXIL_SLV_RANGE_ERR_EN
  localparam bit RANGE_ERR = 1'b1;
`else
  localparam bit RANGE_ERR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [8];

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Reference model: eight words, word index from address bits [5:2].
  function automatic logic [1:0] mdl_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    logic [2:0] w;
    if (RANGE_ERR && idx >= 8) return 2'b10;
    w = 3'(idx % 8);
    for (int b = 0; b < 4; b++) if (s[b]) mem[w][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic void mdl_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a >> 2);
    if (RANGE_ERR && idx >= 8) begin
      d = 32'h0;
      r = 2'b10;
    end else begin
      d = mem[3'(idx % 8)];
      r = 2'b00;
    end
  endfunction

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    resp = 2'bxx; lat = -1;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(negedge clk);
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout_fail("write_handshake");
      return;
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout_fail("write_bvalid"); return; end
    lat = n;
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    bit done, ar_now;
    int n;
    done = 0; n = 0;
    d = 'x; resp = 2'bxx; lat = -1;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    while (!done && n < 50) begin
      ar_now = arready;
      @(negedge clk);
      if (ar_now) begin arvalid = 1'b0; done = 1; end
      n++;
    end
    if (!done) begin arvalid = 1'b0; timeout_fail("read_handshake"); return; end
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin timeout_fail("read_rvalid"); return; end
    lat = n;
    d = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'h0);
    check({tag, "_wready"},  32'(wready),  32'h0);
    check({tag, "_bvalid"},  32'(bvalid),  32'h0);
    check({tag, "_bresp"},   32'(bresp),   32'h0);
    check({tag, "_arready"}, 32'(arready), 32'h0);
    check({tag, "_rvalid"},  32'(rvalid),  32'h0);
    check({tag, "_rdata"},   rdata,        32'h0);
    check({tag, "_rresp"},   32'(rresp),   32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r, er;
    logic [31:0] d, ed;
    logic [5:0]  a;
    logic [3:0]  s;
    int          lat;
    bit          seen;

    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 8; i++) mem[3'(i)] = 32'h0;

    vecs[0] = '{1'b1, 6'h04, 32'hA5A50001, 4'hF, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'hA5A50001};
    vecs[2] = '{1'b1, 6'h08, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vecs[3] = '{1'b1, 6'h08, 32'hFFFFFFFF, 4'h2, 2'b00, 32'h0};
    vecs[4] = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h1122FF44};
    vecs[5] = '{1'b1, 6'h20, 32'hDEADBEEF, 4'hF, RANGE_ERR ? 2'b10 : 2'b00, 32'h0};
    vecs[6] = '{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, RANGE_ERR ? 32'h0 : 32'hDEADBEEF};
    vecs[7] = '{1'b0, 6'h20, 32'h0,        4'h0, RANGE_ERR ? 2'b10 : 2'b00, RANGE_ERR ? 32'h0 : 32'hDEADBEEF};
    vecs[8] = '{1'b1, 6'h10, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vecs[9] = '{1'b0, 6'h10, 32'h0,        4'h0, 2'b00, 32'h0};

    // Power-on reset
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    areset = 1'b0;
    @(negedge clk);
    check("post_reset_awready", 32'(awready), 32'h1);
    check("post_reset_wready",  32'(wready),  32'h1);
    check("post_reset_arready", 32'(arready), 32'h1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        void'(mdl_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        if (i == 0) check("write_latency", 32'(lat), 32'd1);
      end else begin
        axi_read(vecs[i].addr, d, r, lat);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        if (i == 1) check("read_latency", 32'(lat), 32'd0);
      end
    end

    // W three cycles ahead of AW, with BREADY held low
    bready = 1'b0;
    @(negedge clk);
    check("early_w_wready_idle", 32'(wready), 32'h1);
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("early_w_wready_held", 32'(wready), 32'h0);
    check("early_w_no_bvalid", 32'(bvalid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("early_w_awready", 32'(awready), 32'h1);
    awaddr = 6'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("early_w_bvalid_pre_commit", 32'(bvalid), 32'h0);
    @(negedge clk);
    check("early_w_bvalid_commit", 32'(bvalid), 32'h1);
    check("early_w_bresp", 32'(bresp), 32'h0);
    repeat (4) begin
      @(negedge clk);
      check("stall_bvalid", 32'(bvalid), 32'h1);
      check("stall_awready", 32'(awready), 32'h0);
      check("stall_wready", 32'(wready), 32'h0);
    end
    bready = 1'b1;
    @(negedge clk);
    check("stall_bvalid_drop", 32'(bvalid), 32'h0);
    @(negedge clk);
    check("stall_awready_back", 32'(awready), 32'h1);
    check("stall_wready_back", 32'(wready), 32'h1);
    void'(mdl_write(6'h14, 32'h0BADF00D, 4'hF));
    axi_read(6'h14, d, r, lat);
    check("early_w_readback", d, 32'h0BADF00D);

    // Commit and AR to the same register on one edge
    axi_write(6'h0C, 32'h1, 4'hF, r, lat);
    void'(mdl_write(6'h0C, 32'h1, 4'hF));
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awaddr = 6'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("collide_bvalid", 32'(bvalid), 32'h1);
    check("collide_rvalid", 32'(rvalid), 32'h1);
    check("collide_rdata_old", rdata, 32'h1);
    bready = 1'b1;
    @(negedge clk);
    check("collide_rvalid_hold", 32'(rvalid), 32'h1);
    check("collide_rdata_hold", rdata, 32'h1);
    rready = 1'b1;
    @(negedge clk);
    void'(mdl_write(6'h0C, 32'h5, 4'hF));
    axi_read(6'h0C, d, r, lat);
    check("collide_readback", d, 32'h5);

    // Reset one cycle after an AW-only handshake
    @(negedge clk);
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    areset = 1'b0;
    @(negedge clk);
    check("midreset_awready", 32'(awready), 32'h1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bvalid) seen = 1;
    end
    check("midreset_no_bvalid", 32'(seen), 32'h0);
    for (int i = 0; i < 8; i++) mem[3'(i)] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      axi_read(6'(i * 4), d, r, lat);
      check($sformatf("midreset_reg%0d", i), d, 32'h0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 80; k++) begin
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, r, lat);
        er = mdl_write(a, d, s);
        check($sformatf("rand%0d_bresp_a%h", k, a), 32'(r), 32'(er));
      end else begin
        axi_read(a, d, r, lat);
        mdl_read(a, ed, er);
        check($sformatf("rand%0d_rdata_a%h", k, a), d, ed);
        check($sformatf("rand%0d_rresp_a%h", k, a), 32'(r), 32'(er));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
